// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: EX/MEM bundle field positions,
// FSM state encodings, flags-word layout and the default stack pointer value.
package memory_stage_pkg;

    // EX/MEM bundle field positions
    localparam int unsigned IN_W         = 106;
    localparam int unsigned B_INPORT_HI  = 98;
    localparam int unsigned B_INPORT_LO  = 83;
    localparam int unsigned B_NEXTPC_HI  = 82;
    localparam int unsigned B_NEXTPC_LO  = 51;
    localparam int unsigned B_RSRC_HI    = 50;
    localparam int unsigned B_RSRC_LO    = 35;
    localparam int unsigned B_ALU_HI     = 34;
    localparam int unsigned B_ALU_LO     = 19;
    localparam int unsigned B_RDST_HI    = 15;
    localparam int unsigned B_RDST_LO    = 13;
    localparam int unsigned B_PUSH       = 11;
    localparam int unsigned B_POP        = 10;
    localparam int unsigned B_RET        = 9;
    localparam int unsigned B_RTI        = 8;
    localparam int unsigned B_LDD        = 7;
    localparam int unsigned B_IN         = 6;
    localparam int unsigned B_OUT        = 5;
    localparam int unsigned B_CALL       = 3;
    localparam int unsigned B_MEMWRITE   = 1;
    localparam int unsigned B_WB         = 0;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CALL_LO = 2'd1;
    localparam logic [1:0] ST_RTI_LO  = 2'd2;
    localparam logic [1:0] ST_RET_HI  = 2'd3;

    // Bit positions of the saved flags inside the RTI flags word
    localparam int unsigned FLAG_CF_BIT = 2;
    localparam int unsigned FLAG_NF_BIT = 1;
    localparam int unsigned FLAG_ZF_BIT = 0;

    // Stack starts at the top of memory and grows downward
    localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if #(
    parameter int unsigned DMEM_AW = 16
);
    logic [DMEM_AW-1:0] MemAddr;
    logic [15:0]        MemWData;
    logic               MemWE;
    logic [15:0]        MemRData;

    modport master (
        output MemAddr,
        output MemWData,
        output MemWE,
        input  MemRData
    );

    modport slave (
        input  MemAddr,
        input  MemWData,
        input  MemWE,
        output MemRData
    );
endinterface

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register with increment/decrement/hold control and an
// SP+1 address output used by pops and return sequences.
module stack_pointer_unit #(
    parameter int unsigned        DMEM_AW  = 16,
    parameter logic [DMEM_AW-1:0] SP_RESET = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    output logic [DMEM_AW-1:0] sp,
    output logic [DMEM_AW-1:0] sp_plus1
);

    localparam logic [DMEM_AW-1:0] SP_ONE = {{(DMEM_AW-1){1'b0}}, 1'b1};

    logic [DMEM_AW-1:0] sp_q;
    logic [DMEM_AW-1:0] sp_d;

    // Next SP: increment wins over decrement, otherwise hold; wraps modulo 2^DMEM_AW
    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + SP_ONE;
        end else if (dec) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    // SP register, asynchronously reset to the top of the stack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + SP_ONE;

endmodule

// File: rtl/memory_stage.sv
// Fourth pipeline stage: data-memory loads/stores, PUSH/POP and the
// multi-word CALL/RET/RTI stack sequences. Owns SP and the output port.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned        DMEM_AW  = 16,
    parameter logic [DMEM_AW-1:0] SP_RESET = DMEM_AW'(SP_RESET_DEFAULT)
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [IN_W-1:0]    In,
    memory_stage_if.master     mem,
    output logic [19:0]        Out,
    output logic [15:0]        OutPort,
    output logic               Stall,
    output logic               PcLoad,
    output logic [31:0]        PcTarget,
    output logic               FlagsLoad,
    output logic [2:0]         FlagsValue,
    output logic [DMEM_AW-1:0] SP
);

    logic [15:0] alu_result, rsrc_value, in_port;
    logic [31:0] next_pc;
    logic [2:0]  rdst;

    assign alu_result = In[B_ALU_HI:B_ALU_LO];
    assign rsrc_value = In[B_RSRC_HI:B_RSRC_LO];
    assign in_port    = In[B_INPORT_HI:B_INPORT_LO];
    assign next_pc    = In[B_NEXTPC_HI:B_NEXTPC_LO];
    assign rdst       = In[B_RDST_HI:B_RDST_LO];

    // Flags, jump bits, RsrcAddr and the upstream iteration hints are not needed here
    logic unused_in;
    assign unused_in = ^{In[105:99], In[18:16], In[12], In[4], In[2]};

    logic [1:0]  state_q, state_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] outport_q, outport_d;

    logic               sp_inc, sp_dec;
    logic [DMEM_AW-1:0] sp_cur, sp_plus1;

    logic [DMEM_AW-1:0] mem_addr;
    logic [15:0]        mem_wdata;
    logic               mem_we;
    logic               wb;
    logic [15:0]        wb_value;
    logic               stall;
    logic               pc_load;
    logic [31:0]        pc_target;
    logic               flags_load;
    logic [2:0]         flags_value;

    stack_pointer_unit #(
        .DMEM_AW  (DMEM_AW),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk      (CLK),
        .rst      (Reset),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp_cur),
        .sp_plus1 (sp_plus1)
    );

    // Op decode with priority in IDLE, stack-sequence continuation otherwise;
    // every combinational output is forced to zero while Reset is high
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        outport_d   = outport_q;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        wb          = In[B_WB];
        wb_value    = alu_result;
        stall       = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        flags_load  = 1'b0;
        flags_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (In[B_RTI]) begin
                    mem_addr    = sp_plus1;
                    flags_value = {mem.MemRData[FLAG_CF_BIT],
                                   mem.MemRData[FLAG_NF_BIT],
                                   mem.MemRData[FLAG_ZF_BIT]};
                    flags_load  = 1'b1;
                    sp_inc      = 1'b1;
                    wb          = 1'b0;
                    stall       = 1'b1;
                    state_d     = ST_RTI_LO;
                end else if (In[B_RET]) begin
                    mem_addr = sp_plus1;
                    lo_d     = mem.MemRData;
                    sp_inc   = 1'b1;
                    wb       = 1'b0;
                    stall    = 1'b1;
                    state_d  = ST_RET_HI;
                end else if (In[B_CALL]) begin
                    mem_addr  = sp_cur;
                    mem_wdata = next_pc[31:16];
                    mem_we    = 1'b1;
                    sp_dec    = 1'b1;
                    wb        = 1'b0;
                    stall     = 1'b1;
                    state_d   = ST_CALL_LO;
                end else if (In[B_PUSH]) begin
                    mem_addr  = sp_cur;
                    mem_wdata = alu_result;
                    mem_we    = 1'b1;
                    sp_dec    = 1'b1;
                end else if (In[B_POP]) begin
                    mem_addr = sp_plus1;
                    wb_value = mem.MemRData;
                    sp_inc   = 1'b1;
                end else if (In[B_MEMWRITE]) begin
                    mem_addr  = DMEM_AW'(alu_result);
                    mem_wdata = rsrc_value;
                    mem_we    = 1'b1;
                end else if (In[B_LDD]) begin
                    mem_addr = DMEM_AW'(alu_result);
                    wb_value = mem.MemRData;
                end else if (In[B_IN]) begin
                    wb_value = in_port;
                end else if (In[B_OUT]) begin
                    outport_d = alu_result;
                end
            end
            ST_CALL_LO: begin
                mem_addr  = sp_cur;
                mem_wdata = next_pc[15:0];
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                wb        = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_RTI_LO: begin
                mem_addr = sp_plus1;
                lo_d     = mem.MemRData;
                sp_inc   = 1'b1;
                wb       = 1'b0;
                stall    = 1'b1;
                state_d  = ST_RET_HI;
            end
            ST_RET_HI: begin
                mem_addr  = sp_plus1;
                pc_target = {mem.MemRData, lo_q};
                pc_load   = 1'b1;
                sp_inc    = 1'b1;
                wb        = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (Reset) begin
            sp_inc      = 1'b0;
            sp_dec      = 1'b0;
            mem_addr    = '0;
            mem_wdata   = '0;
            mem_we      = 1'b0;
            wb          = 1'b0;
            wb_value    = '0;
            stall       = 1'b0;
            pc_load     = 1'b0;
            pc_target   = '0;
            flags_load  = 1'b0;
            flags_value = '0;
        end
    end

    // Sequence state, latched PC low word and output port register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            lo_q      <= '0;
            outport_q <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            outport_q <= outport_d;
        end
    end

    assign mem.MemAddr  = mem_addr;
    assign mem.MemWData = mem_wdata;
    assign mem.MemWE    = mem_we;

    assign Out        = Reset ? 20'h0 : {wb, rdst, wb_value};
    assign OutPort    = outport_q;
    assign Stall      = stall;
    assign PcLoad     = pc_load;
    assign PcTarget   = pc_target;
    assign FlagsLoad  = flags_load;
    assign FlagsValue = flags_value;
    assign SP         = sp_cur;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single-cycle ops, then hand-written
// CALL/RET/RTI, asynchronous reset and SP wrap sequences.
module tb_memory_stage;

    localparam logic [12:0] C_PUSH = 13'h0800;
    localparam logic [12:0] C_POP  = 13'h0400;
    localparam logic [12:0] C_RET  = 13'h0200;
    localparam logic [12:0] C_RTI  = 13'h0100;
    localparam logic [12:0] C_LDD  = 13'h0080;
    localparam logic [12:0] C_IN   = 13'h0040;
    localparam logic [12:0] C_OUT  = 13'h0020;
    localparam logic [12:0] C_CALL = 13'h0008;
    localparam logic [12:0] C_MR   = 13'h0004;
    localparam logic [12:0] C_MW   = 13'h0002;
    localparam logic [12:0] C_WB   = 13'h0001;

    logic         CLK;
    logic         rst0, rst1;
    logic [105:0] in0, in1;
    logic [19:0]  out0, out1;
    logic [15:0]  oport0, oport1;
    logic         stall0, stall1;
    logic         pcl0, pcl1;
    logic [31:0]  pct0, pct1;
    logic         fl0, fl1;
    logic [2:0]   fv0, fv1;
    logic [15:0]  sp0, sp1;

    int n_chk  = 0;
    int n_fail = 0;

    memory_stage_if #(.DMEM_AW(16)) mif0 ();
    memory_stage_if #(.DMEM_AW(16)) mif1 ();

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    assign mif0.MemRData = mem0[mif0.MemAddr];
    assign mif1.MemRData = mem1[mif1.MemAddr];

    always @(posedge CLK) begin
        if (mif0.MemWE) mem0[mif0.MemAddr] <= mif0.MemWData;
        if (mif1.MemWE) mem1[mif1.MemAddr] <= mif1.MemWData;
    end

    memory_stage #(.DMEM_AW(16)) dut0 (
        .CLK(CLK), .Reset(rst0), .In(in0), .mem(mif0), .Out(out0), .OutPort(oport0),
        .Stall(stall0), .PcLoad(pcl0), .PcTarget(pct0), .FlagsLoad(fl0),
        .FlagsValue(fv0), .SP(sp0)
    );

    memory_stage #(.DMEM_AW(16), .SP_RESET(16'h0000)) dut1 (
        .CLK(CLK), .Reset(rst1), .In(in1), .mem(mif1), .Out(out1), .OutPort(oport1),
        .Stall(stall1), .PcLoad(pcl1), .PcTarget(pct1), .FlagsLoad(fl1),
        .FlagsValue(fv1), .SP(sp1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Ignored bits [105:99] are set to ones so that they are shown to have no effect
    function automatic logic [105:0] mk(input logic [12:0] ctl, input logic [2:0] rdst,
                                        input logic [15:0] alu, input logic [15:0] rsrc,
                                        input logic [15:0] inport, input logic [31:0] npc);
        logic [105:0] v;
        v          = '0;
        v[105:99]  = 7'h7F;
        v[98:83]   = inport;
        v[82:51]   = npc;
        v[50:35]   = rsrc;
        v[34:19]   = alu;
        v[15:13]   = rdst;
        v[12:0]    = ctl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [105:0] in;
        logic         chk_addr;
        logic [15:0]  addr;
        logic         we;
        logic [15:0]  wdata;
        logic [19:0]  out;
        logic [15:0]  sp;
        logic [15:0]  outport;
    } vec_t;

    vec_t vt [9];

    initial begin
        // in, chk_addr, addr, we, wdata, Out, SP after edge, OutPort after edge
        vt[0] = '{mk(C_PUSH | C_MW, 3'd0, 16'h1234, 16'h0, 16'h0, 32'h0), 1'b1, 16'hFFFF, 1'b1, 16'h1234, 20'h01234, 16'hFFFE, 16'h0000};
        vt[1] = '{mk(C_POP | C_MR | C_WB, 3'd3, 16'h0, 16'h0, 16'h0, 32'h0), 1'b1, 16'hFFFF, 1'b0, 16'h0, 20'hB1234, 16'hFFFF, 16'h0000};
        vt[2] = '{mk(C_MW, 3'd0, 16'h0010, 16'hABCD, 16'h0, 32'h0), 1'b1, 16'h0010, 1'b1, 16'hABCD, 20'h00010, 16'hFFFF, 16'h0000};
        vt[3] = '{mk(C_LDD | C_MR | C_WB, 3'd5, 16'h0010, 16'h0, 16'h0, 32'h0), 1'b1, 16'h0010, 1'b0, 16'h0, 20'hDABCD, 16'hFFFF, 16'h0000};
        vt[4] = '{mk(C_IN | C_WB, 3'd2, 16'h0, 16'h0, 16'h7777, 32'h0), 1'b0, 16'h0, 1'b0, 16'h0, 20'hA7777, 16'hFFFF, 16'h0000};
        vt[5] = '{mk(C_OUT, 3'd0, 16'h00FF, 16'h0, 16'h0, 32'h0), 1'b0, 16'h0, 1'b0, 16'h0, 20'h000FF, 16'hFFFF, 16'h00FF};
        vt[6] = '{mk(C_WB, 3'd1, 16'h4321, 16'h0, 16'h0, 32'h0), 1'b0, 16'h0, 1'b0, 16'h0, 20'h94321, 16'hFFFF, 16'h00FF};
        vt[7] = '{mk(C_PUSH | C_POP | C_MW, 3'd0, 16'h5555, 16'h0, 16'h0, 32'h0), 1'b1, 16'hFFFF, 1'b1, 16'h5555, 20'h05555, 16'hFFFE, 16'h00FF};
        vt[8] = '{mk(C_POP | C_MR | C_WB, 3'd4, 16'h0, 16'h0, 16'h0, 32'h0), 1'b1, 16'hFFFF, 1'b0, 16'h0, 20'hC5555, 16'hFFFF, 16'h00FF};

        rst0 = 1'b1;
        rst1 = 1'b1;
        in0  = '0;
        in1  = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("reset_sp", {16'h0, sp0}, 32'hFFFF);
        chk("reset_outport", {16'h0, oport0}, 32'h0);
        chk("reset_sp_wrapdut", {16'h0, sp1}, 32'h0000);

        // Single-cycle ops
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            in0 = vt[i].in;
            #2;
            if (vt[i].chk_addr) chk($sformatf("v%0d_addr", i), {16'h0, mif0.MemAddr}, {16'h0, vt[i].addr});
            chk($sformatf("v%0d_we", i), {31'h0, mif0.MemWE}, {31'h0, vt[i].we});
            if (vt[i].we) chk($sformatf("v%0d_wdata", i), {16'h0, mif0.MemWData}, {16'h0, vt[i].wdata});
            chk($sformatf("v%0d_out", i), {12'h0, out0}, {12'h0, vt[i].out});
            chk($sformatf("v%0d_stall", i), {31'h0, stall0}, 32'h0);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_sp", i), {16'h0, sp0}, {16'h0, vt[i].sp});
            chk($sformatf("v%0d_outport", i), {16'h0, oport0}, {16'h0, vt[i].outport});
        end

        // Asynchronous reset mid-cycle while a CALL is pending
        @(negedge CLK);
        in0 = mk(C_PUSH | C_MW, 3'd0, 16'h0A0A, 16'h0, 16'h0, 32'h0);
        @(posedge CLK);
        #1;
        chk("pre_rst_sp", {16'h0, sp0}, 32'hFFFE);
        @(negedge CLK);
        in0 = mk(C_CALL | C_WB, 3'd1, 16'h0, 16'h0, 16'h0, 32'h0003_0004);
        #1;
        chk("pre_rst_stall", {31'h0, stall0}, 32'h1);
        #1;
        rst0 = 1'b1;
        #1;
        chk("rst_sp", {16'h0, sp0}, 32'hFFFF);
        chk("rst_outport", {16'h0, oport0}, 32'h0);
        chk("rst_stall", {31'h0, stall0}, 32'h0);
        chk("rst_out", {12'h0, out0}, 32'h0);
        chk("rst_we", {31'h0, mif0.MemWE}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        in0  = '0;
        rst0 = 1'b0;

        // CALL then RET
        @(negedge CLK);
        in0 = mk(C_CALL | C_WB, 3'd1, 16'h0, 16'h0, 16'h0, 32'h0001_0020);
        #2;
        chk("call1_addr", {16'h0, mif0.MemAddr}, 32'hFFFF);
        chk("call1_we", {31'h0, mif0.MemWE}, 32'h1);
        chk("call1_wdata", {16'h0, mif0.MemWData}, 32'h0001);
        chk("call1_stall", {31'h0, stall0}, 32'h1);
        chk("call1_wb", {31'h0, out0[19]}, 32'h0);
        @(posedge CLK);
        #1;
        chk("call1_sp", {16'h0, sp0}, 32'hFFFE);
        @(negedge CLK);
        #2;
        chk("call2_addr", {16'h0, mif0.MemAddr}, 32'hFFFE);
        chk("call2_we", {31'h0, mif0.MemWE}, 32'h1);
        chk("call2_wdata", {16'h0, mif0.MemWData}, 32'h0020);
        chk("call2_stall", {31'h0, stall0}, 32'h0);
        chk("call2_wb", {31'h0, out0[19]}, 32'h0);
        @(posedge CLK);
        #1;
        chk("call2_sp", {16'h0, sp0}, 32'hFFFD);
        chk("call_mem_hi", {16'h0, mem0[16'hFFFF]}, 32'h0001);
        chk("call_mem_lo", {16'h0, mem0[16'hFFFE]}, 32'h0020);
        @(negedge CLK);
        in0 = mk(C_RET | C_WB, 3'd2, 16'h0, 16'h0, 16'h0, 32'h0);
        #2;
        chk("ret1_addr", {16'h0, mif0.MemAddr}, 32'hFFFE);
        chk("ret1_stall", {31'h0, stall0}, 32'h1);
        chk("ret1_pcload", {31'h0, pcl0}, 32'h0);
        chk("ret1_we", {31'h0, mif0.MemWE}, 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        #2;
        chk("ret2_addr", {16'h0, mif0.MemAddr}, 32'hFFFF);
        chk("ret2_pcload", {31'h0, pcl0}, 32'h1);
        chk("ret2_target", pct0, 32'h0001_0020);
        chk("ret2_stall", {31'h0, stall0}, 32'h0);
        chk("ret2_wb", {31'h0, out0[19]}, 32'h0);
        @(posedge CLK);
        #1;
        chk("ret_sp", {16'h0, sp0}, 32'hFFFF);

        // RTI frame built with three pushes: FFFF=0002, FFFE=0040, FFFD=0005
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            case (i)
                0: in0 = mk(C_PUSH | C_MW, 3'd0, 16'h0002, 16'h0, 16'h0, 32'h0);
                1: in0 = mk(C_PUSH | C_MW, 3'd0, 16'h0040, 16'h0, 16'h0, 32'h0);
                default: in0 = mk(C_PUSH | C_MW, 3'd0, 16'h0005, 16'h0, 16'h0, 32'h0);
            endcase
            @(posedge CLK);
        end
        #1;
        chk("rti_pre_sp", {16'h0, sp0}, 32'hFFFC);
        @(negedge CLK);
        in0 = mk(C_RTI | C_WB, 3'd3, 16'h0, 16'h0, 16'h0, 32'h0);
        #2;
        chk("rti1_addr", {16'h0, mif0.MemAddr}, 32'hFFFD);
        chk("rti1_flagsload", {31'h0, fl0}, 32'h1);
        chk("rti1_flags", {29'h0, fv0}, 32'h5);
        chk("rti1_stall", {31'h0, stall0}, 32'h1);
        chk("rti1_pcload", {31'h0, pcl0}, 32'h0);
        chk("rti1_wb", {31'h0, out0[19]}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #2;
        chk("rti2_stall", {31'h0, stall0}, 32'h1);
        chk("rti2_flagsload", {31'h0, fl0}, 32'h0);
        chk("rti2_pcload", {31'h0, pcl0}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #2;
        chk("rti3_pcload", {31'h0, pcl0}, 32'h1);
        chk("rti3_target", pct0, 32'h0002_0040);
        chk("rti3_stall", {31'h0, stall0}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rti_sp", {16'h0, sp0}, 32'hFFFF);
        @(negedge CLK);
        in0 = '0;
        #2;
        chk("post_rti_pcload", {31'h0, pcl0}, 32'h0);

        // SP_RESET=0000: push/pop wrap, then reset after the first CALL cycle
        @(negedge CLK);
        in1 = mk(C_PUSH | C_MW, 3'd0, 16'hBEEF, 16'h0, 16'h0, 32'h0);
        #2;
        chk("wrap_push_addr", {16'h0, mif1.MemAddr}, 32'h0000);
        chk("wrap_push_we", {31'h0, mif1.MemWE}, 32'h1);
        @(posedge CLK);
        #1;
        chk("wrap_push_sp", {16'h0, sp1}, 32'hFFFF);
        @(negedge CLK);
        in1 = mk(C_POP | C_MR | C_WB, 3'd6, 16'h0, 16'h0, 16'h0, 32'h0);
        #2;
        chk("wrap_pop_addr", {16'h0, mif1.MemAddr}, 32'h0000);
        chk("wrap_pop_out", {12'h0, out1}, 32'h000E_BEEF);
        @(posedge CLK);
        #1;
        chk("wrap_pop_sp", {16'h0, sp1}, 32'h0000);
        @(negedge CLK);
        in1 = mk(C_CALL, 3'd0, 16'h0, 16'h0, 16'h0, 32'h1234_5678);
        #2;
        chk("abort_call1_we", {31'h0, mif1.MemWE}, 32'h1);
        chk("abort_call1_wdata", {16'h0, mif1.MemWData}, 32'h1234);
        @(posedge CLK);
        #2;
        chk("abort_call1_sp", {16'h0, sp1}, 32'hFFFF);
        rst1 = 1'b1;
        #1;
        chk("abort_sp", {16'h0, sp1}, 32'h0000);
        chk("abort_we", {31'h0, mif1.MemWE}, 32'h0);
        chk("abort_stall", {31'h0, stall1}, 32'h0);
        @(negedge CLK);
        rst1 = 1'b0;
        in1  = '0;
        #2;
        chk("abort_idle_we", {31'h0, mif1.MemWE}, 32'h0);
        chk("abort_idle_pcload", {31'h0, pcl1}, 32'h0);
        @(posedge CLK);
        #1;
        chk("abort_idle_sp", {16'h0, sp1}, 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Fourth pipeline stage. Consumes the 106-bit EX/MEM bundle produced by the execute stage and performs data-memory loads and stores, single-word PUSH/POP, and multi-word CALL/RET/RTI stack sequences. Owns the stack pointer and the output-port register. Drives the MEM/WB result, the memory-level forwarding triple back to execute, PC redirect and flag restore, and a stall to upstream stages.

Parameters:
DMEM_AW, 16, data-memory word-address width; SP width.
SP_RESET, all-ones (16'hFFFF), stack pointer value after reset; the stack grows downward.

Ports:
CLK  in  1  stage clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
In  in  106  EX/MEM bundle: [105]CF [104]NF [103]ZF [102]JMP [101]JC [100]JN [99]JZ [98:83]InPort [82:51]NextPC [50:35]RsrcValue [34:19]AluResult [18:16]RsrcAddr [15:13]RdstAddr [12]PrvsStackOp [11]PUSH [10]POP [9]RET [8]RTI [7]LDD [6]IN [5]OUT [4]ScndIteration [3]CALL [2]MemRead [1]MemWrite [0]WB.
MemAddr  out  DMEM_AW  data-memory word address.
MemWData  out  16  store data.
MemWE  out  1  write enable; memory writes on the CLK edge.
MemRData  in  16  read data, combinational from MemAddr.
Out  out  20  {WB, RdstAddr[2:0], WBValue[15:0]} to the MEM/WB register; the same value is the memory forwarding triple.
OutPort  out  16  registered output port.
Stall  out  1  1 = hold In and freeze upstream stages.
PcLoad  out  1  one-cycle pulse; load PcTarget into the PC.
PcTarget  out  32  return address.
FlagsLoad  out  1  one-cycle pulse; restore flags.
FlagsValue  out  3  {CF,NF,ZF} to restore.
SP  out  DMEM_AW  current stack pointer (debug and observation).

Behaviour:
- Reset (async): SP=SP_RESET, OutPort=0, state=IDLE, latched low PC word=0. While Reset is high, all combinational outputs are 0.
- Bits [105:99], [12] and [4] of In are ignored. This block sequences its own iterations.
- One-hot ops are guaranteed by the decoder. If more than one is set, priority is RTI > RET > CALL > PUSH > POP > STD > LDD > IN > OUT. All-zero control is a bubble: no memory access, Out.WB=In[0].
- Single-cycle ops, all completing in IDLE with Stall=0:
  - STD: MemAddr=AluResult, MemWData=RsrcValue, MemWE=1.
  - LDD: MemAddr=AluResult, WBValue=MemRData.
  - PUSH: MemAddr=SP, MemWData=AluResult, MemWE=1, SP<=SP-1.
  - POP: MemAddr=SP+1, WBValue=MemRData, SP<=SP+1.
  - IN: WBValue=InPort.
  - OUT: OutPort<=AluResult.
  - Otherwise: WBValue=AluResult.
- Stack frame layout: PC high word at the higher address, PC low word directly below it. RTI additionally has a flags word below PC low, with flags in bits [2:0].
- FSM states: IDLE, CALL_LO, RTI_LO, RET_HI. Stall=1 in every cycle of a multi-word op except its last.
  - CALL: in IDLE, write NextPC[31:16] at SP, SP-=1, go to CALL_LO (Stall=1). In CALL_LO, write NextPC[15:0] at SP, SP-=1, go to IDLE (Stall=0). Total latency 2 cycles.
  - RET: in IDLE, read SP+1 and latch it as the low word, SP+=1, go to RET_HI (Stall=1). In RET_HI, read SP+1, PcTarget={MemRData, low}, PcLoad=1, SP+=1, go to IDLE. Total latency 2 cycles.
  - RTI: in IDLE, read SP+1, FlagsValue=MemRData[2:0], FlagsLoad=1, SP+=1, go to RTI_LO (Stall=1). In RTI_LO, latch the low word, SP+=1, go to RET_HI. Total latency 3 cycles.
- Out.WB=0 for CALL/RET/RTI in every cycle.
- SP arithmetic is modulo 2^DMEM_AW. There is no overflow or underflow detection.
- Reset asserted mid-sequence aborts it: FSM to IDLE, SP to SP_RESET, no PcLoad.
- In must stay stable while Stall=1. The block samples op fields only in IDLE.

Decomposition:
- Shared package: In field bit-position constants, FSM state encoding, flags-word bit positions, SP_RESET default.
- One natural sub-module: stack_pointer_unit. It holds the SP register and provides inc/dec/hold control plus the SP+1 address output.

Test Plan:
1. Reset asserted mid-cycle -> SP=FFFF, OutPort=0, Stall=0, Out=0 immediately, without waiting for a clock edge.
2. PUSH AluResult=1234 -> MemWE=1, MemAddr=FFFF, MemWData=1234, SP=FFFE. Then POP RdstAddr=3 -> MemAddr=FFFF, Out={1,3,1234}, SP=FFFF.
3. CALL NextPC=0001_0020 -> cycle 1: write FFFF=0001, Stall=1. Cycle 2: write FFFE=0020, Stall=0, SP=FFFD. Then RET -> cycle 1: read FFFE, Stall=1. Cycle 2: read FFFF, PcLoad=1, PcTarget=00010020, SP=FFFF.
4. Preload FFFF=0002, FFFE=0040, FFFD=0005 with SP=FFFC, then RTI -> cycle 1: FlagsLoad=1, FlagsValue=101. Cycle 3: PcLoad=1, PcTarget=00020040. Stall=1,1,0. SP=FFFF.
5. STD AluResult=0010, RsrcValue=ABCD writes mem[0010]=ABCD. LDD AluResult=0010, Rdst=5 -> Out={1,5,ABCD}. IN InPort=7777 -> WBValue=7777. OUT AluResult=00FF -> OutPort=00FF on the next edge.
6. SP_RESET=0000: PUSH -> write addr 0000, SP=FFFF (wrap). POP -> read 0000, SP=0000. Reset after the first CALL cycle -> state IDLE, SP=SP_RESET, no second write.
